// File: rtl/memory_stage_load_store_unit.sv
// MEM-stage load/store unit: runs the EX/MEM memory request on an
// Avalon-MM data bus with waitrequest, stalls until it completes,
// aligns and extends load data, and flags bad requests.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   mem_read_memory       load request
//   mem_write_memory      store request
//   mem_size_memory       00 byte, 01 half, 10 word, 11 illegal
//   mem_signed_memory     sign-extend sub-word loads
//   address_memory        byte address
//   write_data_memory     right-justified store data
//   read_data_memory      extended load result (held)
//   stall_memory          pipeline freeze
//   address_error_memory  combinational bad-request flag
//   avm_*                 Avalon-MM master signals
//
// Build option: LSU_PARTIAL_WORD_EN enables byte/half accesses;
// without it only aligned word accesses are legal.

`timescale 1ns/1ps

module memory_stage_load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_memory,
  input  logic        mem_write_memory,
  input  logic [1:0]  mem_size_memory,
  input  logic        mem_signed_memory,
  input  logic [31:0] address_memory,
  input  logic [31:0] write_data_memory,
  output logic [31:0] read_data_memory,
  output logic        stall_memory,
  output logic        address_error_memory,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0]  off;
  logic        any_req;
  logic        one_req;
  logic        aligned;
  logic        valid_req;
  logic        issue;
  logic        accept;
  logic [31:0] wd_lane;
  logic [31:0] ld_ext;

  assign off     = address_memory[1:0];
  assign any_req = mem_read_memory | mem_write_memory;
  assign one_req = mem_read_memory ^ mem_write_memory;

  // Size/alignment legality of the presented request.
  always_comb begin
    aligned = 1'b0;
`ifdef LSU_PARTIAL_WORD_EN
    unique case (mem_size_memory)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
`else
    aligned = (mem_size_memory == 2'b10) &&
              (off == 2'b00);
`endif
  end

  assign valid_req = one_req & aligned;
  assign issue     = (state_q == S_IDLE) & valid_req;
  assign accept    = (state_q == S_BUS) & ~avm_waitrequest;

  // Never flagged while a bus access is in flight.
  assign address_error_memory =
    any_req & ~valid_req & (state_q != S_BUS);

  assign stall_memory = issue | (state_q == S_BUS);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (valid_req) state_d = S_BUS;
      S_BUS:   if (!avm_waitrequest) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LSU_PARTIAL_WORD_EN
  logic [3:0]  be_lane;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store lanes: replicate so the slave sees data on any lane.
  always_comb begin
    be_lane = 4'b1111;
    wd_lane = write_data_memory;
    unique case (mem_size_memory)
      2'b00: begin
        be_lane = 4'b0001 << off;
        wd_lane = {4{write_data_memory[7:0]}};
      end
      2'b01: begin
        be_lane = off[1] ? 4'b1100 : 4'b0011;
        wd_lane = {2{write_data_memory[15:0]}};
      end
      default: begin
        be_lane = 4'b1111;
        wd_lane = write_data_memory;
      end
    endcase
  end

  // Load lanes use the request captured at issue time.
  always_comb begin
    ld_byte = avm_readdata[7:0];
    unique case (off_q)
      2'b00: ld_byte = avm_readdata[7:0];
      2'b01: ld_byte = avm_readdata[15:8];
      2'b10: ld_byte = avm_readdata[23:16];
      default: ld_byte = avm_readdata[31:24];
    endcase
    ld_half = off_q[1] ? avm_readdata[31:16]
                       : avm_readdata[15:0];
    ld_ext = avm_readdata;
    unique case (size_q)
      2'b00:
        ld_ext = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:
        ld_ext = {{16{sgn_q & ld_half[15]}}, ld_half};
      default:
        ld_ext = avm_readdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avm_byteenable <= 4'b0000;
      off_q          <= 2'b00;
      size_q         <= 2'b10;
      sgn_q          <= 1'b0;
    end else if (issue) begin
      avm_byteenable <= be_lane;
      off_q          <= off;
      size_q         <= mem_size_memory;
      sgn_q          <= mem_signed_memory;
    end
  end
`else
  logic unused_sign;

  assign unused_sign    = mem_signed_memory;
  assign avm_byteenable = 4'b1111;
  assign wd_lane        = write_data_memory;
  assign ld_ext         = avm_readdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      avm_address      <= 32'h0;
      avm_writedata    <= 32'h0;
      avm_read         <= 1'b0;
      avm_write        <= 1'b0;
      read_data_memory <= 32'h0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        avm_address   <= {address_memory[31:2], 2'b00};
        avm_writedata <= wd_lane;
        avm_read      <= mem_read_memory;
        avm_write     <= mem_write_memory;
      end
      if (accept) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
        if (avm_read) read_data_memory <= ld_ext;
      end
    end
  end

endmodule

// File: doc/memory_stage_load_store_unit.md
# memory_stage_load_store_unit

Load/store unit for the MEM stage of the pipelined MIPS core. It takes the memory request held in the EX/MEM pipeline register and runs it on an Avalon-MM-style data bus with waitrequest. It aligns and sign- or zero-extends load data into `read_data_memory`, which the MEM/WB register captures. It stalls the pipeline until the bus access completes and flags misaligned accesses instead of issuing them.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high
- `mem_read_memory`  in  1  load request from EX/MEM
- `mem_write_memory`  in  1  store request from EX/MEM
- `mem_size_memory`  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal
- `mem_signed_memory`  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
- `address_memory`  in  32  byte address (ALU output)
- `write_data_memory`  in  32  store data, right-justified
- `read_data_memory`  out  32  extended load result; holds its value until the next load completes
- `stall_memory`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; MEM/WB receives a bubble while this is high
- `address_error_memory`  out  1  single-cycle combinational flag for a misaligned, illegal or conflicting request
- `avm_address`  out  32  word address: `{address[31:2], 2'b00}`
- `avm_read`  out  1  registered read strobe
- `avm_write`  out  1  registered write strobe
- `avm_writedata`  out  32  store data replicated onto its byte lanes
- `avm_byteenable`  out  4  active byte lanes, little-endian
- `avm_readdata`  in  32  read data; valid in the cycle `avm_read` is high and `avm_waitrequest` is low
- `avm_waitrequest`  in  1  slave not ready; the command must be held while this is high

## Operation
The unit is a three-state FSM: IDLE, BUS, DONE. Reset puts it in IDLE.

Request validity:
- A request is valid when exactly one of `mem_read_memory` or `mem_write_memory` is high and the access is aligned.
- Misaligned means: half access with `addr[0]` = 1, word access with `addr[1:0]` ≠ 0, size 11, or read and write both high.
- An invalid request drives `address_error_memory` high while it is presented. It starts no bus access and does not stall.

State transitions:
- IDLE with a valid request: `stall_memory` = 1 combinationally. On the next edge, load the `avm_*` registers (address, byteenable, lane-replicated writedata, strobe) and go to BUS.
- BUS: `stall_memory` = 1. Hold every `avm_*` output stable while `avm_waitrequest` = 1.
- BUS with `avm_waitrequest` = 0: on that edge, drop the strobe and go to DONE. For reads, also capture the extended lane data into `read_data_memory`.
- DONE: `stall_memory` = 0, so the pipeline advances the completed request. Return to IDLE unconditionally.
- The request that follows is first evaluated in IDLE, so the same access is never issued twice.

Byte-lane rules:
- Byte: byteenable = `1 << addr[1:0]`. Writedata = `{4{wd[7:0]}}`. Load data = byte `addr[1:0]`, extended.
- Half: byteenable = 0011 if `addr[1]` = 0, else 1100. Writedata = `{2{wd[15:0]}}`. Load data = the selected halfword, extended.
- Word: byteenable = 1111, data passes through unchanged.

Reset:
- Reset values: `avm_read`, `avm_write`, `avm_address`, `avm_writedata`, `avm_byteenable` and `read_data_memory` are all 0.
- `stall_memory` and `address_error_memory` reset to 0 whenever the request inputs are idle.
- Reset asserted mid-access aborts it immediately. The strobes drop asynchronously and the FSM returns to IDLE with no completion.

## Timing
- A load or store with zero wait states stalls for 2 cycles: cycle 0 IDLE (stall), cycle 1 BUS (strobe high, accepted), cycle 2 DONE (no stall, data valid).
- Each cycle of `avm_waitrequest` = 1 adds one stall cycle.
- `read_data_memory` is registered and valid from the DONE cycle onward, so MEM/WB captures it on the edge that leaves DONE.
- Back-to-back accesses are separated by one DONE cycle. Steady-state throughput is one access per 3 cycles at zero wait states.
- `address_error_memory` is purely combinational from the request inputs and is asserted only in IDLE or DONE.

## Configuration
Macro `LSU_PARTIAL_WORD_EN`:
- Defined: byte and half accesses behave as described in Operation.
- Undefined: only word accesses are legal. Sizes 00, 01 and 11 raise `address_error_memory` with no bus access. `avm_byteenable` is constant 1111 and the extension logic is removed. `mem_signed_memory` is ignored.

## Test plan
- Word load, address 0x0000_1004, readdata 0xDEAD_BEEF, waitrequest always 0: stall high for exactly 2 cycles; avm_address 0x0000_1004; read_data_memory 0xDEAD_BEEF in DONE.
- Signed byte load at 0x...1003 with readdata 0x80FF_FF7F: result 0xFFFF_FF80. The same load unsigned returns 0x0000_0080.
- Half store of 0x1234_ABCD at 0x...2002 with waitrequest high for 3 cycles: byteenable 1100; writedata 0xABCD_ABCD held for all 4 BUS cycles; stall lasts 5 cycles.
- Word load at 0x...0006: address_error_memory high, no stall, avm_read never asserted.
- Reset pulse during BUS with waitrequest held high: avm_read drops within the reset cycle; after release the FSM is in IDLE and read_data_memory is 0.
- With `LSU_PARTIAL_WORD_EN` undefined, a byte load at 0x...0000 raises address_error_memory and issues no bus access.
